// File: rtl/ise_pkg.sv
// Shared constants, types and the dominant-colour rule for the image sorting engine.
package ise_pkg;

    localparam int IMAGE_NUM   = 32;
    localparam int IMAGE_SIZE  = 128;
    localparam int PIX_PER_IMG = IMAGE_SIZE * IMAGE_SIZE;
    localparam int CNT_W       = 15;
    localparam int SUM_W       = 22;

    typedef logic [1:0] color_t;

    localparam color_t COLOR_R = 2'd0;
    localparam color_t COLOR_G = 2'd1;
    localparam color_t COLOR_B = 2'd2;

    typedef struct packed {
        color_t      color;
        logic [7:0]  intensity;
        logic        emitted;
    } entry_t;

    // Same priority order serves pixel classes and image winners: red > green > blue on ties.
    function automatic color_t dominant(input logic [CNT_W-1:0] r,
                                        input logic [CNT_W-1:0] g,
                                        input logic [CNT_W-1:0] b);
        color_t res;
        if (r >= g && r >= b) res = COLOR_R;
        else if (g >= b)      res = COLOR_G;
        else                  res = COLOR_B;
        return res;
    endfunction

endpackage

// File: rtl/ise_div.sv
// Sequential restoring divider (22-bit dividend / 15-bit divisor), one quotient bit per cycle.
module ise_div
    import ise_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [7:0]       quotient
);

    logic [SUM_W-1:0] quo, quo_src, quo_step;
    logic [CNT_W-1:0] rem, rem_src, rem_step;
    logic [CNT_W:0]   shifted;
    logic [4:0]       cnt;
    logic             running;

    // The start cycle already performs the first iteration, saving one busy cycle per image.
    always_comb begin
        rem_src = start ? '0 : rem;
        quo_src = start ? dividend : quo;
        shifted = {rem_src, quo_src[SUM_W-1]};
        if (shifted >= {1'b0, divisor}) begin
            rem_step = CNT_W'(shifted - {1'b0, divisor});
            quo_step = {quo_src[SUM_W-2:0], 1'b1};
        end else begin
            rem_step = shifted[CNT_W-1:0];
            quo_step = {quo_src[SUM_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= rem_step;
                quo     <= quo_step;
                cnt     <= 5'(SUM_W - 1);
                running <= 1'b1;
            end else if (running) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    // Winning sum <= 255 * winning count, so the quotient always fits in 8 bits.
    assign quotient = quo[7:0];

endmodule

// File: rtl/ise_sorter.sv
// Image sorting engine: classifies streamed images, tabulates colour/intensity, emits indices in key order.
module ise_sorter #(
    parameter int IMAGE_SIZE = ise_pkg::IMAGE_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  image_in_index,
    input  logic [23:0] pixel_in,
    output logic        busy,
    output logic        out_valid,
    output logic [1:0]  color_index,
    output logic [4:0]  image_out_index
);
    import ise_pkg::*;

    typedef enum logic [2:0] {S_RECV, S_DIV, S_STORE, S_SORT, S_EMIT, S_DONE} state_t;

    localparam logic [13:0] LAST_PIX = 14'(IMAGE_SIZE * IMAGE_SIZE - 1);

    state_t           state, state_next;
    logic [13:0]      pix_cnt;
    logic [CNT_W-1:0] cnt [3];
    logic [SUM_W-1:0] sum [3];
    logic [4:0]       cur_index, img_cnt, emit_cnt, scan_idx, best_idx;
    logic [9:0]       best_key, cand_key;
    logic             best_found;
    entry_t           img_table [IMAGE_NUM];
    logic             div_start, div_done;
    logic [7:0]       div_quotient, pix_val;
    color_t           pix_class, win_color;
    logic [CNT_W-1:0] win_cnt;
    logic [SUM_W-1:0] win_sum;
    logic             accept, last_pix;

    // busy is low only in RECV, so it doubles as the pixel-accept qualifier.
    assign accept    = !busy;
    assign last_pix  = accept && (pix_cnt == LAST_PIX);
    assign pix_class = dominant(CNT_W'(pixel_in[23:16]), CNT_W'(pixel_in[15:8]), CNT_W'(pixel_in[7:0]));
    assign win_color = dominant(cnt[0], cnt[1], cnt[2]);
    assign win_cnt   = cnt[win_color];
    assign win_sum   = sum[win_color];
    assign cand_key  = {img_table[scan_idx].color, img_table[scan_idx].intensity};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pix_val = pixel_in[7:0];
        case (pix_class)
            COLOR_R: pix_val = pixel_in[23:16];
            COLOR_G: pix_val = pixel_in[15:8];
            default: pix_val = pixel_in[7:0];
        endcase
    end

    ise_div u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (win_sum),
        .divisor  (win_cnt),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_RECV:  if (last_pix) state_next = S_DIV;
            S_DIV:   if (div_done) state_next = S_STORE;
            S_STORE: state_next = (img_cnt == 5'd31) ? S_SORT : S_RECV;
            S_SORT:  if (scan_idx == 5'd31) state_next = S_EMIT;
            S_EMIT:  state_next = (emit_cnt == 5'd31) ? S_DONE : S_SORT;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_RECV;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_RECV;
            busy            <= 1'b0;
            out_valid       <= 1'b0;
            color_index     <= '0;
            image_out_index <= '0;
            pix_cnt         <= '0;
            cur_index       <= '0;
            img_cnt         <= '0;
            emit_cnt        <= '0;
            scan_idx        <= '0;
            best_idx        <= '0;
            best_key        <= '0;
            best_found      <= 1'b0;
            div_start       <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                cnt[c] <= '0;
                sum[c] <= '0;
            end
            // NOTE: the table is reset explicitly; stale emitted flags would corrupt the next run.
            for (int i = 0; i < IMAGE_NUM; i++) img_table[i] <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != S_RECV);
            div_start <= last_pix;
            out_valid <= 1'b0;

            if (accept) begin
                pix_cnt        <= last_pix ? 14'd0 : pix_cnt + 14'd1;
                cnt[pix_class] <= cnt[pix_class] + CNT_W'(1);
                sum[pix_class] <= sum[pix_class] + SUM_W'(pix_val);
                cur_index      <= image_in_index;
            end

            case (state)
                S_STORE: begin
                    img_table[cur_index] <= '{color: win_color, intensity: div_quotient, emitted: 1'b0};
                    img_cnt              <= img_cnt + 5'd1;
                    for (int c = 0; c < 3; c++) begin
                        cnt[c] <= '0;
                        sum[c] <= '0;
                    end
                end
                S_SORT: begin
                    // Strict compare on an ascending scan resolves key ties to the lower index.
                    if (!img_table[scan_idx].emitted && (!best_found || cand_key < best_key)) begin
                        best_key   <= cand_key;
                        best_idx   <= scan_idx;
                        best_found <= 1'b1;
                    end
                    scan_idx <= scan_idx + 5'd1;
                end
                S_EMIT: begin
                    out_valid                  <= 1'b1;
                    color_index                <= best_key[9:8];
                    image_out_index            <= best_idx;
                    img_table[best_idx].emitted <= 1'b1;
                    emit_cnt                   <= emit_cnt + 5'd1;
                    best_found                 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ise_sorter.sv
// Scoreboard bench for ise_sorter: reference model computes sorted keys, monitor checks the output stream.
module tb_ise_sorter;

    localparam int TB_SIZE = 8;
    localparam int PIX     = TB_SIZE * TB_SIZE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  image_in_index;
    logic [23:0] pixel_in;
    logic        busy, out_valid;
    logic [1:0]  color_index;
    logic [4:0]  image_out_index;

    ise_sorter #(.IMAGE_SIZE(TB_SIZE)) dut (
        .clk             (clk),
        .reset           (reset),
        .image_in_index  (image_in_index),
        .pixel_in        (pixel_in),
        .busy            (busy),
        .out_valid       (out_valid),
        .color_index     (color_index),
        .image_out_index (image_out_index)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    int          exp_q[$];
    logic [23:0] img_px [32][PIX];
    int          order [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected key per out_valid pulse.
    always @(negedge clk) begin
        int k;
        if (reset === 1'b0 && out_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                k = exp_q.pop_front();
                check("out_color", 32'(color_index), 32'(k >> 13));
                check("out_index", 32'(image_out_index), 32'(k & 31));
            end
        end
    end

    task automatic do_reset();
        reset          = 1'b1;
        image_in_index = 'x;
        pixel_in       = 'x;
        @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_color", 32'(color_index), 32'd0);
        check("reset_index", 32'(image_out_index), 32'd0);
        exp_q.delete();
        pulses = 0;
        reset  = 1'b0;
    endtask

    // Presents one pixel and holds it until an edge with busy low takes it.
    task automatic send_pixel(input int idx, input logic [23:0] px);
        logic b;
        image_in_index = 5'(idx);
        pixel_in       = px;
        for (int n = 0; n < 200; n++) begin
            b = busy;
            @(posedge clk);
            #1;
            if (!b) return;
        end
        check("pixel_accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_image(input int idx, input bit last);
        int n;
        for (int p = 0; p < PIX; p++) send_pixel(idx, img_px[idx][p]);
        check("busy_after_image", 32'(busy), 32'd1);
        if (!last) begin
            n = 0;
            while (busy && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("busy_window_le_24", 32'(n <= 24 && !busy), 32'd1);
        end
    endtask

    // Reference model: per-image class statistics, then a plain sort of packed keys.
    task automatic build_expected();
        int keys[$];
        int cnt[3];
        int sum[3];
        int r, g, b, cls, win;
        for (int i = 0; i < 32; i++) begin
            cnt = '{0, 0, 0};
            sum = '{0, 0, 0};
            for (int p = 0; p < PIX; p++) begin
                r = int'(img_px[i][p][23:16]);
                g = int'(img_px[i][p][15:8]);
                b = int'(img_px[i][p][7:0]);
                if (r >= g && r >= b) begin cls = 0; sum[0] += r; end
                else if (g >= b)      begin cls = 1; sum[1] += g; end
                else                  begin cls = 2; sum[2] += b; end
                cnt[cls]++;
            end
            if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) win = 0;
            else if (cnt[1] >= cnt[2])                win = 1;
            else                                      win = 2;
            keys.push_back(win * 8192 + (sum[win] / cnt[win]) * 32 + i);
        end
        keys.sort();
        foreach (keys[i]) exp_q.push_back(keys[i]);
    endtask

    task automatic gen_images(input int mode);
        int r, j, t;
        for (int i = 0; i < 32; i++) begin
            order[i] = i;
            for (int p = 0; p < PIX; p++) begin
                case (mode)
                    0: img_px[i][p] = {8'(i * 4), 16'h0};
                    1: img_px[i][p] = (i < 10) ? 24'h006400 : (i <= 20) ? 24'h000032 : 24'hC80000;
                    2: begin
                        r = (i == 17) ? 28 : 31 - i;
                        img_px[i][p] = {8'(r), 16'h0};
                    end
                    default: img_px[i][p] = 24'($urandom());
                endcase
                if (mode == 3 && i == 0) img_px[i][p] = (p < PIX / 2 + 1) ? 24'h0A0000 : 24'h0000FF;
                if (mode == 3 && i == 1) img_px[i][p] = (p < PIX / 2) ? 24'h070707 : 24'h000900;
            end
        end
        if (mode >= 3) begin
            for (int i = 31; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
    endtask

    task automatic run(input int mode);
        int n;
        do_reset();
        gen_images(mode);
        build_expected();
        for (int k = 0; k < 32; k++) send_image(order[k], k == 31);
        n = 0;
        while (pulses < 32 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (40) @(posedge clk);
        #1;
        check("pulse_count", 32'(pulses), 32'd32);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
    endtask

    initial begin
        for (int m = 0; m < 5; m++) run(m);
        // Abort a run mid-image; the following run must start clean.
        do_reset();
        for (int p = 0; p < 20; p++) send_pixel(3, 24'($urandom()));
        run(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
